ball_ctrl: RTL and testbench
============================

# ball_ctrl

Frame-rate ball engine for the pong datapath, producing the ball position consumed by both `paddle` instances (`ball_x`/`ball_y`) and by the pixel renderer. It advances the ball once per `frame_tick` and bounces it off the top/bottom walls and the two paddles, whose upper-left corners and sizes it takes from the `paddle` outputs. It detects misses, keeps per-side scores and sequences serve / play / score / game-over.

## Interface
- `BALL_SIZE`, 8, ball edge length in pixels (square)
- `SPEED`, 2, initial horizontal and vertical step per frame, pixels
- `MAX_SPEED`, 6, horizontal step ceiling (used only with speed-up)
- `SERVE_DELAY`, 60, frames the ball rests at centre before launch
- `WIN_SCORE`, 7, score that ends the game
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `frame_tick`  in  1  one-cycle pulse per video frame
- `left_x`, `right_x`  in  10 each  paddle upper-left X
- `left_y`, `right_y`  in  9 each  paddle upper-left Y
- `pad_width`  in  6  paddle width in pixels
- `pad_length`  in  9  paddle length in pixels
- `ball_x`  out  10  ball upper-left X
- `ball_y`  out  9  ball upper-left Y
- `score_l`, `score_r`  out  4 each  points won by each side
- `hit`  out  1  one-cycle pulse on a paddle bounce
- `point`  out  1  one-cycle pulse when a point is scored
- `game_over`  out  1  high while in OVER

## Operation
- States:
  - SERVE: ball held at centre; a frame counter runs. After `SERVE_DELAY` ticks, go to PLAY.
  - PLAY: ball moves once per tick.
  - SCORE: lasts one clock. Pulses `point`, increments the scoring side, then goes to OVER if that score equals `WIN_SCORE`, else to SERVE.
  - OVER: ball frozen; left only by reset.
- Centre position: X = (640 − `BALL_SIZE`)/2 = 316, Y = (480 − `BALL_SIZE`)/2 = 236.
- Direction state: `dx_pos` and `dy_pos` sign bits.
- Serve direction:
  - After reset, the ball serves right and down.
  - After each point, the ball serves toward the side that conceded; `dy_pos` is kept as it was.
- PLAY step, all intermediate arithmetic signed 12-bit:
  - Compute `nx = ball_x ± sx` and `ny = ball_y ± SPEED`.
  - Vertical: if `ny` ≤ 0, clamp Y to 0 and set `dy_pos`. If `ny` ≥ 480 − `BALL_SIZE`, clamp Y to that value and clear `dy_pos`.
  - Left-moving ball:
    - Left-paddle contact: `nx` ≤ `left_x` + `pad_width`, AND `ball_y` + `BALL_SIZE` > `left_y`, AND `ball_y` < `left_y` + `pad_length`.
    - On contact, clamp X to `left_x` + `pad_width`, set `dx_pos` and pulse `hit`.
    - Otherwise, if `nx` < 0, it is a miss and a right point → SCORE.
  - Right-moving ball: mirror image, with the paddle face at `right_x` − `BALL_SIZE` and miss at `nx` > 640 − `BALL_SIZE`.
- Vertical overlap uses the pre-step `ball_y`.
- Wall and paddle events in the same tick are both applied.
- A miss overrides the vertical update: the ball is left at its last position until SERVE recentres it.
- Scores saturate at 15. They clear only on reset.

## Timing
- Outputs are registered. `ball_x`/`ball_y` update on the clock edge after the cycle in which `frame_tick` is sampled high (latency 1).
- `hit` and `point` are high for exactly one clock.
- `frame_tick` is ignored in SCORE and OVER.
- Reset values:
  - `ball_x` = 316, `ball_y` = 236
  - `score_l` = `score_r` = 0
  - `hit` = `point` = `game_over` = 0
  - state SERVE, frame counter 0, `sx` = `SPEED`, `dx_pos` = `dy_pos` = 1
- Reset asserted mid-PLAY returns every register to those values immediately (asynchronous assert); resuming is synchronous to `clk`.
- Paddle inputs are sampled in the tick cycle only. They must be stable for that cycle.

## Configuration
- Macro: `BALL_SPEEDUP_EN`.
- Defined: each paddle hit does `sx` ← min(`sx` + 1, `MAX_SPEED`); `sx` resets to `SPEED` on entering SERVE.
- Undefined: `sx` is constant `SPEED`, `MAX_SPEED` is unused and no speed register exists.

## Structure
- Shared `pong_pkg` contents:
  - field constants: `SCREEN_W` = 640, `SCREEN_H` = 480
  - state enum: SERVE/PLAY/SCORE/OVER
  - coordinate width constants: 10 for X, 9 for Y
- One sub-module, `ball_hit_detect`: combinational paddle-overlap and face-position test, instantiated once per side.

## Test plan
- Reset → `ball_x` = 316, `ball_y` = 236, scores 0; after 60 ticks, the first PLAY tick gives X = 318, Y = 238.
- Ball at Y = 1 moving up with `SPEED` 2 → Y = 0, then next tick Y = 2 (moving down).
- Left paddle at X = 0, Y = 200, width 8, length 64; ball at X = 9, Y = 220 moving left → X = 8, `hit` pulses, `dx_pos` = 1.
- Same ball with the paddle at Y = 300 → ball continues left; at X = 1 the next tick gives `point`, `score_r` = 1, SERVE at centre, then serve moves left.
- `score_l` = 6 with `WIN_SCORE` 7, then right miss → `score_l` = 7, `game_over` = 1, ball frozen across 100 ticks.
- With `BALL_SPEEDUP_EN`: 6 consecutive hits → `sx` sequence 3, 4, 5, 6, 6, 6; after a point, `sx` = 2.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: playfield size, coordinate widths, game states
// and a small saturating score helper.
package pong_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int X_W      = 10;
   localparam int Y_W      = 9;
   localparam int CALC_W   = 12;
   localparam int SCORE_W  = 4;

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      SCORE = 2'd2,
      OVER  = 2'd3
   } game_state_e;

   // Scores stick at their maximum instead of wrapping back to zero.
   function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/ball_hit_detect.sv
// Paddle contact test for one side: checks that the ball's pre-step rows
// overlap the paddle and that the proposed X has reached the paddle face.
// The face is the right edge of a left paddle, or the left edge minus the
// ball size for a right paddle.
module ball_hit_detect
   import pong_pkg::*;
#(
   parameter bit RIGHT_SIDE = 1'b0,
   parameter int BALL_SIZE  = 8
) (
   input  logic signed [CALC_W-1:0] nextX_i,
   input  logic        [Y_W-1:0]    ballY_i,
   input  logic        [X_W-1:0]    padX_i,
   input  logic        [Y_W-1:0]    padY_i,
   input  logic        [5:0]        padWidth_i,
   input  logic        [8:0]        padLength_i,
   output logic                     contact_o,
   output logic signed [CALC_W-1:0] faceX_o
);

   localparam logic signed [CALC_W-1:0] BALL_EXT = CALC_W'(BALL_SIZE);

   logic signed [CALC_W-1:0] ballTop;
   logic signed [CALC_W-1:0] padTop;
   logic signed [CALC_W-1:0] padLeft;
   logic signed [CALC_W-1:0] padWide;
   logic signed [CALC_W-1:0] padLong;
   logic                     overlap;

   assign ballTop = {{(CALC_W-Y_W){1'b0}}, ballY_i};
   assign padTop  = {{(CALC_W-Y_W){1'b0}}, padY_i};
   assign padLeft = {{(CALC_W-X_W){1'b0}}, padX_i};
   assign padWide = {{(CALC_W-6){1'b0}}, padWidth_i};
   assign padLong = {{(CALC_W-9){1'b0}}, padLength_i};

   // Vertical overlap of the ball's current rows with the paddle, then the
   // face position and whether the proposed X has crossed it.
   always_comb begin
      overlap = ((ballTop + BALL_EXT) > padTop) && (ballTop < (padTop + padLong));
      if (RIGHT_SIDE) begin
         faceX_o   = padLeft - BALL_EXT;
         contact_o = overlap && (nextX_i >= faceX_o);
      end else begin
         faceX_o   = padLeft + padWide;
         contact_o = overlap && (nextX_i <= faceX_o);
      end
   end

endmodule

// File: rtl/ball_ctrl.sv
// Frame-rate ball engine: serves from centre, moves the ball once per frame
// tick, bounces it off walls and paddles, detects misses and keeps score.
// Optional feature macro BALL_SPEEDUP_EN: each paddle hit raises the
// horizontal step by one up to MAX_SPEED; the step returns to SPEED after
// every point. Without the macro the horizontal step is fixed at SPEED.
module ball_ctrl
   import pong_pkg::*;
#(
   parameter int BALL_SIZE   = 8,
   parameter int SPEED       = 2,
   parameter int MAX_SPEED   = 6,
   parameter int SERVE_DELAY = 60,
   parameter int WIN_SCORE   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic [X_W-1:0]   left_x,
   input  logic [X_W-1:0]   right_x,
   input  logic [Y_W-1:0]   left_y,
   input  logic [Y_W-1:0]   right_y,
   input  logic [5:0]       pad_width,
   input  logic [8:0]       pad_length,
   output logic [X_W-1:0]   ball_x,
   output logic [Y_W-1:0]   ball_y,
   output logic [SCORE_W-1:0] score_l,
   output logic [SCORE_W-1:0] score_r,
   output logic             hit,
   output logic             point,
   output logic             game_over
);

   localparam int STEP_TOP = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
   localparam int SX_W     = $clog2(STEP_TOP + 1);
   localparam int SC_W     = $clog2(SERVE_DELAY + 1);

   localparam logic [X_W-1:0] CENTRE_X = X_W'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [Y_W-1:0] CENTRE_Y = Y_W'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic signed [CALC_W-1:0] X_MAX = CALC_W'(SCREEN_W - BALL_SIZE);
   localparam logic signed [CALC_W-1:0] Y_MAX = CALC_W'(SCREEN_H - BALL_SIZE);
   localparam logic signed [CALC_W-1:0] DY    = CALC_W'(SPEED);
   localparam logic [SC_W-1:0]          SERVE_LAST = SC_W'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0]       WIN_VAL    = SCORE_W'(WIN_SCORE);

   game_state_e          state_q;
   logic [SC_W-1:0]      serveCnt_q;
   logic [X_W-1:0]       ballX_q, ballX_d;
   logic [Y_W-1:0]       ballY_q, ballY_d;
   logic                 dxPos_q, dxPos_d;
   logic                 dyPos_q, dyPos_d;
   logic [SCORE_W-1:0]   scoreL_q, scoreR_q;
   logic                 hit_q, point_q, gameOver_q;
   logic                 rightScored_q;

   logic [SX_W-1:0]          sx;
   logic signed [CALC_W-1:0] curX, curY, nextX, nextY;
   logic                     leftContact, rightContact;
   logic signed [CALC_W-1:0] leftFace, rightFace;
   logic                     paddleHit, missed, rightScores;
   logic [SCORE_W-1:0]       scoreInc;

`ifdef BALL_SPEEDUP_EN
   localparam logic [SX_W-1:0] SX_MAX = SX_W'(MAX_SPEED);
   logic [SX_W-1:0] sx_q;
   assign sx = sx_q;
`else
   assign sx = SX_W'(SPEED);
`endif

   assign curX = {{(CALC_W-X_W){1'b0}}, ballX_q};
   assign curY = {{(CALC_W-Y_W){1'b0}}, ballY_q};

   ball_hit_detect #(.RIGHT_SIDE(1'b0), .BALL_SIZE(BALL_SIZE)) uLeftHit (
      .nextX_i     (nextX),
      .ballY_i     (ballY_q),
      .padX_i      (left_x),
      .padY_i      (left_y),
      .padWidth_i  (pad_width),
      .padLength_i (pad_length),
      .contact_o   (leftContact),
      .faceX_o     (leftFace)
   );

   ball_hit_detect #(.RIGHT_SIDE(1'b1), .BALL_SIZE(BALL_SIZE)) uRightHit (
      .nextX_i     (nextX),
      .ballY_i     (ballY_q),
      .padX_i      (right_x),
      .padY_i      (right_y),
      .padWidth_i  (pad_width),
      .padLength_i (pad_length),
      .contact_o   (rightContact),
      .faceX_o     (rightFace)
   );

   // Proposed ball step for this frame: wall clamps, paddle bounce on the
   // side the ball is heading to, or a miss past that side's edge.
   always_comb begin
      nextX       = dxPos_q ? (curX + CALC_W'(sx)) : (curX - CALC_W'(sx));
      nextY       = dyPos_q ? (curY + DY) : (curY - DY);
      ballX_d     = ballX_q;
      ballY_d     = ballY_q;
      dxPos_d     = dxPos_q;
      dyPos_d     = dyPos_q;
      paddleHit   = 1'b0;
      missed      = 1'b0;
      rightScores = 1'b0;

      if (nextY <= 0) begin
         ballY_d = '0;
         dyPos_d = 1'b1;
      end else if (nextY >= Y_MAX) begin
         ballY_d = Y_MAX[Y_W-1:0];
         dyPos_d = 1'b0;
      end else begin
         ballY_d = nextY[Y_W-1:0];
      end

      if (!dxPos_q) begin
         if (leftContact) begin
            ballX_d   = leftFace[X_W-1:0];
            dxPos_d   = 1'b1;
            paddleHit = 1'b1;
         end else if (nextX < 0) begin
            missed      = 1'b1;
            rightScores = 1'b1;
         end else begin
            ballX_d = nextX[X_W-1:0];
         end
      end else begin
         if (rightContact) begin
            ballX_d   = rightFace[X_W-1:0];
            dxPos_d   = 1'b0;
            paddleHit = 1'b1;
         end else if (nextX > X_MAX) begin
            missed = 1'b1;
         end else begin
            ballX_d = nextX[X_W-1:0];
         end
      end

      scoreInc = rightScored_q ? satInc(scoreR_q) : satInc(scoreL_q);
   end

   // Game sequencer: serve countdown, per-frame motion, one-clock scoring
   // step and the terminal game-over hold, with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= SERVE;
         serveCnt_q    <= '0;
         ballX_q       <= CENTRE_X;
         ballY_q       <= CENTRE_Y;
         dxPos_q       <= 1'b1;
         dyPos_q       <= 1'b1;
         scoreL_q      <= '0;
         scoreR_q      <= '0;
         hit_q         <= 1'b0;
         point_q       <= 1'b0;
         gameOver_q    <= 1'b0;
         rightScored_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         sx_q          <= SX_W'(SPEED);
`endif
      end else begin
         hit_q   <= 1'b0;
         point_q <= 1'b0;
         case (state_q)
            SERVE: begin
               if (frame_tick) begin
                  if (serveCnt_q == SERVE_LAST) begin
                     serveCnt_q <= '0;
                     state_q    <= PLAY;
                  end else begin
                     serveCnt_q <= serveCnt_q + SC_W'(1);
                  end
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (missed) begin
                     state_q       <= SCORE;
                     rightScored_q <= rightScores;
                  end else begin
                     ballX_q <= ballX_d;
                     ballY_q <= ballY_d;
                     dxPos_q <= dxPos_d;
                     dyPos_q <= dyPos_d;
                     hit_q   <= paddleHit;
`ifdef BALL_SPEEDUP_EN
                     if (paddleHit) begin
                        sx_q <= (sx_q >= SX_MAX) ? SX_MAX : sx_q + SX_W'(1);
                     end
`endif
                  end
               end
            end
            SCORE: begin
               point_q <= 1'b1;
`ifdef BALL_SPEEDUP_EN
               sx_q    <= SX_W'(SPEED);
`endif
               if (rightScored_q) begin
                  scoreR_q <= scoreInc;
               end else begin
                  scoreL_q <= scoreInc;
               end
               if (scoreInc == WIN_VAL) begin
                  state_q    <= OVER;
                  gameOver_q <= 1'b1;
               end else begin
                  state_q <= SERVE;
                  ballX_q <= CENTRE_X;
                  ballY_q <= CENTRE_Y;
                  dxPos_q <= ~rightScored_q;
               end
            end
            OVER: begin
            end
            default: state_q <= SERVE;
         endcase
      end
   end

   assign ball_x    = ballX_q;
   assign ball_y    = ballY_q;
   assign score_l   = scoreL_q;
   assign score_r   = scoreR_q;
   assign hit       = hit_q;
   assign point     = point_q;
   assign game_over = gameOver_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed rallies with fixed paddles, async reset
// checks and a randomized phase, all compared every cycle against a
// behavioural game model kept here.
module tb_ball_ctrl;

   localparam int BALL_SIZE   = 8;
   localparam int SPEED       = 2;
   localparam int MAX_SPEED   = 6;
   localparam int SERVE_DELAY = 60;
   localparam int WIN_SCORE   = 7;
   localparam int CX          = (640 - BALL_SIZE) / 2;
   localparam int CY          = (480 - BALL_SIZE) / 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic [9:0] left_x, right_x;
   logic [8:0] left_y, right_y;
   logic [5:0] pad_width;
   logic [8:0] pad_length;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [3:0] score_l, score_r;
   logic       hit, point, game_over;

   int  nChecks = 0;
   int  nErrors = 0;
   bit  compareOn = 0;

   ball_ctrl #(
      .BALL_SIZE(BALL_SIZE), .SPEED(SPEED), .MAX_SPEED(MAX_SPEED),
      .SERVE_DELAY(SERVE_DELAY), .WIN_SCORE(WIN_SCORE)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .left_x(left_x), .right_x(right_x), .left_y(left_y), .right_y(right_y),
      .pad_width(pad_width), .pad_length(pad_length),
      .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
      .hit(hit), .point(point), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Behavioural model of the game, advanced once per clock edge.
   typedef enum {M_WAIT, M_RALLY, M_SCORING, M_FINISHED} phase_e;
   phase_e mPhase;
   int mX, mY, mSx, mScoreL, mScoreR, mServeTicks;
   bit mRight, mDown, mHit, mPoint, mOver, mRightScored;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task modelReset();
      mPhase = M_WAIT; mX = CX; mY = CY; mSx = SPEED;
      mScoreL = 0; mScoreR = 0; mServeTicks = 0;
      mRight = 1; mDown = 1; mHit = 0; mPoint = 0; mOver = 0; mRightScored = 0;
   endtask

   task rallyStep();
      int nx, ny, face;
      bit overlapL, overlapR, missNow;
      nx = mRight ? mX + mSx : mX - mSx;
      ny = mDown ? mY + SPEED : mY - SPEED;
      overlapL = (mY + BALL_SIZE > int'(left_y))  && (mY < int'(left_y) + int'(pad_length));
      overlapR = (mY + BALL_SIZE > int'(right_y)) && (mY < int'(right_y) + int'(pad_length));
      missNow = 0;
      if (!mRight) begin
         face = int'(left_x) + int'(pad_width);
         if (nx <= face && overlapL) begin
            nx = face; mRight = 1; mHit = 1;
         end else if (nx < 0) begin
            missNow = 1; mRightScored = 1;
         end
      end else begin
         face = int'(right_x) - BALL_SIZE;
         if (nx >= face && overlapR) begin
            nx = face; mRight = 0; mHit = 1;
         end else if (nx > 640 - BALL_SIZE) begin
            missNow = 1; mRightScored = 0;
         end
      end
      if (missNow) begin
         mPhase = M_SCORING;
      end else begin
         mX = nx;
         if (ny <= 0) begin
            mY = 0; mDown = 1;
         end else if (ny >= 480 - BALL_SIZE) begin
            mY = 480 - BALL_SIZE; mDown = 0;
         end else begin
            mY = ny;
         end
`ifdef BALL_SPEEDUP_EN
         if (mHit) mSx = (mSx + 1 > MAX_SPEED) ? MAX_SPEED : mSx + 1;
`endif
      end
   endtask

   task modelStep();
      int won;
      mHit = 0; mPoint = 0;
      case (mPhase)
         M_WAIT: if (frame_tick) begin
            mServeTicks++;
            if (mServeTicks == SERVE_DELAY) begin
               mServeTicks = 0; mPhase = M_RALLY;
            end
         end
         M_RALLY: if (frame_tick) rallyStep();
         M_SCORING: begin
            mPoint = 1;
            if (mRightScored) begin
               mScoreR = (mScoreR < 15) ? mScoreR + 1 : 15; won = (mScoreR == WIN_SCORE);
            end else begin
               mScoreL = (mScoreL < 15) ? mScoreL + 1 : 15; won = (mScoreL == WIN_SCORE);
            end
            if (won != 0) begin
               mOver = 1; mPhase = M_FINISHED;
            end else begin
               mX = CX; mY = CY; mRight = !mRightScored; mSx = SPEED; mPhase = M_WAIT;
            end
         end
         default: ;
      endcase
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) modelReset();
      else modelStep();
   end

   // Every falling edge out of reset, all outputs must match the model.
   always @(negedge clk) begin
      if (compareOn && !reset) begin
         checkOutput("ball_x", int'(ball_x), mX);
         checkOutput("ball_y", int'(ball_y), mY);
         checkOutput("score_l", int'(score_l), mScoreL);
         checkOutput("score_r", int'(score_r), mScoreR);
         checkOutput("hit", int'(hit), int'(mHit));
         checkOutput("point", int'(point), int'(mPoint));
         checkOutput("game_over", int'(game_over), int'(mOver));
      end
   end

   task automatic applyStimulus(input int nTicks);
      for (int i = 0; i < nTicks; i++) begin
         @(negedge clk) frame_tick = 1'b1;
         @(negedge clk) frame_tick = 1'b0;
      end
   endtask

   task automatic waitScore(input int target, input int maxTicks);
      int n = 0;
      while (int'(score_r) != target && n < maxTicks) begin
         applyStimulus(1);
         n++;
      end
      nChecks++;
      if (n >= maxTicks) begin
         nErrors++;
         $display("[TB] FAIL score_r wait: got %0d, expected %0d within %0d ticks", score_r, target, maxTicks);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", nErrors + 1, nChecks + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1; frame_tick = 1'b0;
      left_x = 10'd0;    left_y = 9'd500;
      right_x = 10'd600; right_y = 9'd0;
      pad_width = 6'd8;  pad_length = 9'd480;
      repeat (3) @(negedge clk);
      reset = 1'b0; compareOn = 1;

      checkOutput("reset ball_x", int'(ball_x), 316);
      checkOutput("reset ball_y", int'(ball_y), 236);
      checkOutput("reset score_l", int'(score_l), 0);
      checkOutput("reset game_over", int'(game_over), 0);

      applyStimulus(SERVE_DELAY + 1);
      checkOutput("first play x", int'(ball_x), 318);
      checkOutput("first play y", int'(ball_y), 238);

      applyStimulus(137);
      checkOutput("right face x", int'(ball_x), 592);
      checkOutput("right hit pulse", int'(hit), 1);

      waitScore(1, 1000);
      checkOutput("after miss score_r", int'(score_r), 1);
      checkOutput("recentred x", int'(ball_x), 316);
      checkOutput("recentred y", int'(ball_y), 236);
      applyStimulus(SERVE_DELAY);
      checkOutput("serve toward loser x", int'(ball_x), 314);

      waitScore(WIN_SCORE, 3000);
      checkOutput("final score_r", int'(score_r), 7);
      checkOutput("final score_l", int'(score_l), 0);
      checkOutput("game_over set", int'(game_over), 1);
      applyStimulus(100);
      checkOutput("game_over held", int'(game_over), 1);

      @(posedge clk); #2 reset = 1'b1;
      #1 checkOutput("async reset score_r", int'(score_r), 0);
      @(negedge clk) reset = 1'b0;
      applyStimulus(SERVE_DELAY + 10);
      @(posedge clk); #3 reset = 1'b1;
      #1 checkOutput("mid-play reset x", int'(ball_x), 316);
      checkOutput("mid-play reset y", int'(ball_y), 236);
      @(negedge clk) reset = 1'b0;

      for (int cyc = 0; cyc < 8000; cyc++) begin
         @(negedge clk);
         if (cyc % 400 == 0) begin
            left_x     = 10'($urandom_range(0, 40));
            right_x    = 10'($urandom_range(580, 639));
            left_y     = 9'($urandom_range(0, 470));
            right_y    = 9'($urandom_range(0, 470));
            pad_width  = 6'($urandom_range(4, 16));
            pad_length = 9'($urandom_range(40, 240));
         end
         if (cyc == 4000) begin
            #2 reset = 1'b1;
            #2 reset = 1'b0;
         end
         frame_tick = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
